// File: rtl/counter_arb_pkg.sv
// Shared types and encodings for the two-port round-robin add counter.
package counter_arb_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Configuration opcodes; 2'b11 is reserved and behaves as NONE
    localparam logic [1:0] CFG_NONE  = 2'b00;
    localparam logic [1:0] CFG_LOAD  = 2'b01;
    localparam logic [1:0] CFG_FORCE = 2'b10;
    localparam logic [1:0] CFG_RSVD  = 2'b11;

    // Wrap an index that is at most 2n-1 back into 0..n-1 without a divider
    function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/counter_arb_ctrl_counter.sv
// Counter primitive: two add ports, SETC replaces the base, SETF overwrites the count.
module Counter #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SETC,
    input  logic             SETF,
    input  logic [WIDTH-1:0] DIN,
    input  logic [WIDTH-1:0] ADD_A,
    input  logic [WIDTH-1:0] ADD_B,
    output logic [WIDTH-1:0] Q,
    output logic [1:0]       CARRY_C
);

    localparam int unsigned SW = WIDTH + 2;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] base_c;
    logic [SW-1:0]    sum_c;

    // Full-width sum keeps the carry bits for the owner's overflow tracking
    always_comb begin
        base_c  = SETC ? DIN : cnt_q;
        sum_c   = SW'(base_c) + SW'(ADD_A) + SW'(ADD_B);
        cnt_d   = SETF ? DIN : sum_c[WIDTH-1:0];
        CARRY_C = sum_c[SW-1:WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q = cnt_q;

endmodule

// File: rtl/counter_arb_ctrl.sv
// Round-robin arbiter granting up to two add requests per cycle into a shared counter,
// with LOAD/FORCE configuration, a RUN/HOLD freeze FSM and a sticky wrap flag.
module counter_arb_ctrl
    import counter_arb_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      NREQ  = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NREQ*WIDTH-1:0] REQ_DATA,
    output logic [NREQ-1:0]       REQ_ACK,
    input  logic [1:0]            CFG_OP,
    input  logic [WIDTH-1:0]      CFG_DATA,
    input  logic                  FREEZE,
    output logic                  FROZEN,
    output logic [WIDTH-1:0]      CNT_OUT,
    output logic                  OVF
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q;
    state_e           state_d;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [WIDTH-1:0] addend_c [NREQ];
    logic             setc_c;
    logic             setf_c;
    logic             grant_en_c;
    logic             hit_a_c;
    logic             hit_b_c;
    logic [PW-1:0]    idx_a_c;
    logic [PW-1:0]    idx_b_c;
    logic [PW-1:0]    scan_c;
    logic [PW-1:0]    last_c;
    logic [NREQ-1:0]  ack_c;
    logic [WIDTH-1:0] add_a_c;
    logic [WIDTH-1:0] add_b_c;
    logic [1:0]       carry_c;
    logic [WIDTH-1:0] cnt;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            addend_c[i] = REQ_DATA[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        setc_c = 1'b0;
        setf_c = 1'b0;
        case (CFG_OP)
            CFG_LOAD:           setc_c = 1'b1;
            CFG_FORCE:          setf_c = 1'b1;
            CFG_NONE, CFG_RSVD: begin end
        endcase
    end

    // Scan from the pointer: first valid requester takes port A, second takes port B
    always_comb begin
        grant_en_c = (state_q == RUN) && !RST && !setf_c;
        hit_a_c    = 1'b0;
        hit_b_c    = 1'b0;
        idx_a_c    = '0;
        idx_b_c    = '0;
        scan_c     = '0;
        ack_c      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_c = PW'(wrap_idx(32'(ptr_q) + k, NREQ));
            if (grant_en_c && REQ_VALID[scan_c]) begin
                if (!hit_a_c) begin
                    hit_a_c = 1'b1;
                    idx_a_c = scan_c;
                end else if (!hit_b_c) begin
                    hit_b_c = 1'b1;
                    idx_b_c = scan_c;
                end
            end
        end
        if (hit_a_c) ack_c[idx_a_c] = 1'b1;
        if (hit_b_c) ack_c[idx_b_c] = 1'b1;
        add_a_c = hit_a_c ? addend_c[idx_a_c] : '0;
        add_b_c = hit_b_c ? addend_c[idx_b_c] : '0;
        last_c  = hit_b_c ? idx_b_c : idx_a_c;
        ptr_d   = hit_a_c ? PW'(wrap_idx(32'(last_c) + 32'd1, NREQ)) : ptr_q;
    end

    Counter #(
        .WIDTH (WIDTH),
        .INIT  (INIT)
    ) u_counter (
        .CLK     (CLK),
        .RST     (RST),
        .SETC    (setc_c),
        .SETF    (setf_c),
        .DIN     (CFG_DATA),
        .ADD_A   (add_a_c),
        .ADD_B   (add_b_c),
        .Q       (cnt),
        .CARRY_C (carry_c)
    );

    // FORCE wins over a wrap in the same cycle
    always_comb begin
        ovf_d = ovf_q;
        if (setf_c) begin
            ovf_d = 1'b0;
        end else if (|carry_c) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:  if (FREEZE)  state_d = HOLD;
            HOLD: if (!FREEZE) state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign REQ_ACK = ack_c;
    assign FROZEN  = (state_q == HOLD);
    assign CNT_OUT = cnt;
    assign OVF     = ovf_q;

endmodule
